// File: rtl/seq_mult.sv
// seq_mult: shift-add WIDTH x WIDTH multiplier, BPC multiplier bits per cycle, signed/unsigned per operation.
// Latency: N = WIDTH/BPC cycles from the accept edge to out_valid (fewer when SEQ_MULT_EARLY_TERM_EN is defined).
// Backpressure: one operation in flight; in_ready stays low until the product is taken; product/out_valid held while out_ready=0.
module seq_mult #(
    parameter int WIDTH = 16,
    parameter int BPC   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int N     = WIDTH / BPC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if ((BPC != 1 && BPC != 2 && BPC != 4) || (WIDTH % BPC) != 0) begin : g_bad_cfg
        $error("seq_mult: BPC must be 1, 2 or 4 and must divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     ma_q;
    logic [WIDTH-1:0]     mb_q;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   product_q;

    logic                 accept;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   step;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   result;
    logic [WIDTH-1:0]     mb_next;
    logic                 last_step;

    assign accept = in_valid & in_ready;

    // Magnitudes fit WIDTH bits unsigned, including -2^(WIDTH-1).
    assign a_mag = (signed_mode & a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (signed_mode & b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign step     = ({{WIDTH{1'b0}}, ma_q} * {{(2*WIDTH-BPC){1'b0}}, mb_q[BPC-1:0]})
                      << (32'(cnt_q) * BPC);
    assign acc_next = acc_q + step;
    assign result   = neg_q ? (~acc_next + 1'b1) : acc_next;
    assign mb_next  = mb_q >> BPC;

`ifdef SEQ_MULT_EARLY_TERM_EN
    // Once no multiplier bits remain the accumulator is final.
    assign last_step = (cnt_q == LAST) || (mb_next == '0);
`else
    assign last_step = (cnt_q == LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_q      <= '0;
            mb_q      <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else if (accept) begin
            ma_q  <= a_mag;
            mb_q  <= b_mag;
            neg_q <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == CALC) begin
            acc_q <= acc_next;
            mb_q  <= mb_next;
            cnt_q <= cnt_q + 1'b1;
            if (last_step) begin
                product_q <= result;
            end
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: BPC=1 and BPC=4 instances, scoreboard of expected products checked on out_valid.
module tb_seq_mult;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sm;
        logic [2*W-1:0] p;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           in_valid;
    logic           out_ready;
    logic           signed_mode;
    logic           sel;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           in_ready1, out_valid1, in_ready4, out_valid4;
    logic [2*W-1:0] product1, product4;
    logic           in_ready, out_valid;
    logic [2*W-1:0] product;

    int             total = 0;
    int             bad = 0;
    logic [2*W-1:0] sb_q[$];

    seq_mult #(.WIDTH(W), .BPC(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & ~sel), .in_ready(in_ready1),
        .a(a), .b(b), .signed_mode(signed_mode),
        .out_valid(out_valid1), .out_ready(out_ready), .product(product1)
    );

    seq_mult #(.WIDTH(W), .BPC(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & sel), .in_ready(in_ready4),
        .a(a), .b(b), .signed_mode(signed_mode),
        .out_valid(out_valid4), .out_ready(out_ready), .product(product4)
    );

    assign in_ready  = sel ? in_ready4  : in_ready1;
    assign out_valid = sel ? out_valid4 : out_valid1;
    assign product   = sel ? product4   : product1;

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        logic signed [2*W-1:0] sx, sy;
        if (sm) begin
            sx = $signed(x);
            sy = $signed(y);
            return sx * sy;
        end
        return {{W{1'b0}}, x} * {{W{1'b0}}, y};
    endfunction

    function automatic int exp_lat(input logic [W-1:0] y, input logic sm, input int bpc);
`ifdef SEQ_MULT_EARLY_TERM_EN
        logic [W-1:0] mag;
        int hb, l;
        mag = (sm && y[W-1]) ? (~y + 1'b1) : y;
        hb = -1;
        for (int i = 0; i < W; i++) if (mag[i]) hb = i;
        l = (hb + bpc) / bpc;
        return (l < 1) ? 1 : l;
`else
        return (y === y) ? W / bpc : W / bpc;
`endif
    endfunction

    // Drive one transaction for a single edge; caller sits on a negedge with in_ready high.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm, input logic [2*W-1:0] exp);
        a = x; b = y; signed_mode = sm; in_valid = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; signed_mode = $urandom;
    endtask

    task automatic wait_valid(output int lat, output bit saw_rdy);
        lat = 0;
        saw_rdy = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) saw_rdy = 1;
            @(negedge clk);
            lat++;
        end
        if (in_ready) saw_rdy = 1;
        if (!out_valid) lat = -1;
    endtask

    task automatic pop_exp(output logic [2*W-1:0] exp);
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        else exp = 'x;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
        a = '0; b = '0; signed_mode = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || product1 !== '0) begin
            bad++; $display("FAIL reset_bpc1: got rdy=%b vld=%b p=%h want 1 0 0", in_ready1, out_valid1, product1);
        end
        total++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || product4 !== '0) begin
            bad++; $display("FAIL reset_bpc4: got rdy=%b vld=%b p=%h want 1 0 0", in_ready4, out_valid4, product4);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed(input logic use4);
        vec_t tbl[6];
        int lat;
        bit saw;
        logic [2*W-1:0] exp;
        tbl[0] = '{16'h0003, 16'h0005, 1'b0, 32'h0000_000F};
        tbl[1] = '{16'hFFFE, 16'h0003, 1'b1, 32'hFFFF_FFFA};
        tbl[2] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
        tbl[4] = '{16'h1234, 16'h5678, 1'b0, 32'h0626_0060};
        tbl[5] = '{16'h0005, 16'hFFFD, 1'b1, 32'hFFFF_FFF1};
        sel = use4;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL dir_ready_pre[%0d] bpc4=%b: got %b want 1", i, use4, in_ready);
            end
            launch(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].p);
            wait_valid(lat, saw);
            pop_exp(exp);
            total++;
            if (lat !== exp_lat(tbl[i].b, tbl[i].sm, use4 ? 4 : 1)) begin
                bad++; $display("FAIL dir_latency[%0d] bpc4=%b: got %0d want %0d", i, use4, lat, exp_lat(tbl[i].b, tbl[i].sm, use4 ? 4 : 1));
            end
            total++;
            if (saw !== 1'b0) begin
                bad++; $display("FAIL dir_ready_busy[%0d] bpc4=%b: got in_ready high want low", i, use4);
            end
            total++;
            if (product !== exp) begin
                bad++; $display("FAIL dir_product[%0d] bpc4=%b: got %h want %h", i, use4, product, exp);
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL dir_retire[%0d] bpc4=%b: got vld=%b rdy=%b want 0 1", i, use4, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        bit saw;
        logic [2*W-1:0] exp, hold;
        sel = 1'b0;
        out_ready = 1'b0;
        launch(16'h1234, 16'h0011, 1'b0, 32'h0001_3574);
        wait_valid(lat, saw);
        pop_exp(exp);
        total++;
        if (product !== exp) begin
            bad++; $display("FAIL bp_product: got %h want %h", product, exp);
        end
        hold = exp;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || product !== hold || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d]: got vld=%b p=%h rdy=%b want 1 %h 0", i, out_valid, product, in_ready, hold);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== hold) begin
            bad++; $display("FAIL bp_release: got vld=%b rdy=%b p=%h want 0 1 %h", out_valid, in_ready, product, hold);
        end
        launch(16'd100, 16'd200, 1'b0, 32'd20000);
        wait_valid(lat, saw);
        pop_exp(exp);
        total++;
        if (product !== exp || lat !== exp_lat(16'd200, 1'b0, 1)) begin
            bad++; $display("FAIL bp_next_op: got p=%h lat=%0d want %h %0d", product, lat, exp, exp_lat(16'd200, 1'b0, 1));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat;
        bit saw;
        logic [2*W-1:0] exp;
        sel = 1'b0;
        launch(16'h1111, 16'h2222, 1'b1, 32'h0246_8642);
        pop_exp(exp);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            bad++; $display("FAIL rst_mid: got rdy=%b vld=%b p=%h want 1 0 0", in_ready, out_valid, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_no_output: got vld=%b want 0", out_valid);
        end
        launch(16'd7, 16'd9, 1'b0, 32'h0000_003F);
        wait_valid(lat, saw);
        pop_exp(exp);
        total++;
        if (product !== exp || lat !== exp_lat(16'd9, 1'b0, 1)) begin
            bad++; $display("FAIL rst_recover: got p=%h lat=%0d want %h %0d", product, lat, exp, exp_lat(16'd9, 1'b0, 1));
        end
        @(negedge clk);
    endtask

    task automatic test_early_term;
        vec_t tbl[3];
        int lat;
        bit saw;
        logic [2*W-1:0] exp;
        tbl[0] = '{16'h1234, 16'h0001, 1'b0, 32'h0000_1234};
        tbl[1] = '{16'hBEEF, 16'h0000, 1'b1, 32'h0000_0000};
        tbl[2] = '{16'h0003, 16'h0100, 1'b0, 32'h0000_0300};
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            launch(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].p);
            wait_valid(lat, saw);
            pop_exp(exp);
            total++;
`ifdef SEQ_MULT_EARLY_TERM_EN
            if (lat !== ((i == 2) ? 9 : 1) || product !== exp) begin
                bad++; $display("FAIL early_term[%0d]: got lat=%0d p=%h want %0d %h", i, lat, product, (i == 2) ? 9 : 1, exp);
            end
`else
            if (lat !== 16 || product !== exp) begin
                bad++; $display("FAIL fixed_latency[%0d]: got lat=%0d p=%h want 16 %h", i, lat, product, exp);
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_random(input logic use4);
        int lat;
        bit saw;
        logic [W-1:0] x, y;
        logic sm;
        logic [2*W-1:0] exp;
        sel = use4;
        for (int i = 0; i < 24; i++) begin
            x = $urandom; y = $urandom; sm = $urandom;
            if (i == 0) x = 16'h8000;
            if (i == 1) y = 16'h7FFF;
            launch(x, y, sm, ref_prod(x, y, sm));
            wait_valid(lat, saw);
            pop_exp(exp);
            total++;
            if (product !== exp || lat !== exp_lat(y, sm, use4 ? 4 : 1) || saw !== 1'b0) begin
                bad++; $display("FAIL rand[%0d] bpc4=%b a=%h b=%h s=%b: got p=%h lat=%0d rdy_seen=%b want %h %0d 0",
                                i, use4, x, y, sm, product, lat, saw, exp, exp_lat(y, sm, use4 ? 4 : 1));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed(1'b0);
        test_directed(1'b1);
        test_backpressure();
        test_reset_mid();
        test_early_term();
        test_random(1'b0);
        test_random(1'b1);
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised, multi-cycle shift-add integer multiplier for the quaternion datapath.
- Successor to the 16x16 single-cycle unsigned array multiplier, which it replaces where area matters more than latency.
- Adds width/throughput parametrisation, per-operation signed/unsigned mode, a valid/ready handshake on both sides, and registered output with backpressure.
- Quaternion product units instantiate several of these in parallel and sequence them.

Parameters:
- WIDTH, 16: operand width in bits; product width is 2*WIDTH.
- BPC, 1: multiplier bits retired per CALC cycle; must divide WIDTH; legal values 1, 2, 4.
- N (localparam), WIDTH/BPC: number of CALC cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  2*WIDTH  registered result.

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE, in_ready=1, out_valid=0, product=0, all internal registers cleared.
- Reset mid-operation abandons the operation; no output is produced.
- States:
  - IDLE: in_ready=1. When in_valid&in_ready, go to CALC.
  - CALC: in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- Accept edge (in_valid & in_ready):
  - Capture the magnitude of a and of b (two's-complement abs if signed_mode, else raw).
  - Capture neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the accumulator; set cnt=0.
- CALC, each cycle:
  - acc += (|a| * low BPC bits of mb) << (cnt*BPC).
  - mb >>= BPC; cnt++.
- Arithmetic and width:
  - acc is 2*WIDTH bits.
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and is held in WIDTH bits unsigned.
- Final CALC cycle (cnt==N-1):
  - product <= neg ? -acc_next : acc_next, truncated to 2*WIDTH.
  - Go to DONE.
- Latency: accept at edge t; out_valid high after edge t+N. Default N=16.
- DONE:
  - product and out_valid are held stable while out_ready=0.
  - On out_valid&out_ready, go to IDLE and clear out_valid. product keeps its value.
  - in_ready is high again the following cycle; no back-to-back overlap.
- in_valid while busy is ignored; the operands are not captured.
- Changes to a, b or signed_mode after acceptance have no effect.
- Unsigned mode never negates. Signed -2^(W-1) * -2^(W-1) = 2^(2W-2), exactly representable.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined:
  - In CALC, if the remaining mb == 0 before the step, skip to DONE on that edge with the sign-corrected acc.
  - Latency = max(1, ceil((index of highest set bit of |b| + 1)/BPC)) cycles; b=0 finishes after 1 CALC cycle.
  - Result is identical to the non-early case.
- Undefined: latency is always exactly N cycles.

Test Plan:
- Unsigned, WIDTH=16, BPC=1: a=3, b=5 -> out_valid exactly 16 cycles after accept, product=0x0000000F. in_ready low throughout.
- Signed: a=0xFFFE (-2), b=0x0003 -> product=0xFFFFFFFA. Signed a=0x8000, b=0x8000 -> 0x40000000. Unsigned a=b=0xFFFF -> 0xFFFE0001.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - product and out_valid stay stable.
  - in_valid pulses are ignored.
  - Release -> IDLE next cycle; new operation accepted.
- Reset mid-CALC: assert rst_n=0 at cycle 7 -> outputs go immediately to reset values. After release, a=7, b=9 completes with 0x0000003F.
- BPC=4, WIDTH=16: a=0x1234, b=0x5678 -> latency 4 cycles, product=0x06260060. Random signed/unsigned sweep matches the reference model.
- With SEQ_MULT_EARLY_TERM_EN, BPC=1:
  - b=1 -> out_valid 1 cycle after accept.
  - b=0 -> product=0 after 1 cycle.
  - b=0x0100 -> 9 cycles.
